sprite_bank: RTL and testbench
==============================

// Module: sprite_bank
// PURPOSE
//  Parametrised bank of NUM_OBJECTS sprite objects (players, missiles, ball) behind one register bus.
//  Each object has a 2-D position, a height, a graphics byte, horizontal stretch, reflection and enable.
//  The bank tracks the video raster and produces one per-pixel value bit per object, plus a latched
//  pairwise collision matrix that software can read and clear. Sits in peripherals beside hdmi.
// PARAMETERS
//  NUM_OBJECTS  5   object channels, 2..8
//  GFX_WIDTH    8   graphics bits per object line
//  POS_WIDTH    10  width of hpos/vpos and position registers
// PORTS
//  clk          in   1   system clock; every register is on its rising edge
//  reset        in   1   asynchronous, active-low reset
//  pixel_en     in   1   one-cycle strobe per displayed pixel
//  hpos         in   POS_WIDTH  raster column, valid when pixel_en is high
//  vpos         in   POS_WIDTH  raster line, valid when pixel_en is high
//  enable       in   1   bus select
//  write_enable in   1   bus write (qualified by enable)
//  address      in   7   register address
//  data_in      in   8   write data
//  data_out     out  8   registered read data
//  obj_value    out  NUM_OBJECTS  per-object pixel value, bit i = object i
// BEHAVIOUR
//  Reset: all object registers, shadows, collision bits, data_out and obj_value go to 0; all FSMs to IDLE.
//   A reset asserted mid-draw aborts the draw at once.
//  Register map, object i at base 8*i:
//   +0 posx[7:0]   +1 posx[POS_WIDTH-1:8]   +2 posy[7:0]   +3 posy[POS_WIDTH-1:8]
//   +4 height (lines)   +5 gfx[GFX_WIDTH-1:0]   +6 ctrl {en[7], refl[3], stretch[1:0]}
//  Global: 0x78..0x7B collision[31:0] (byte 0 at 0x78, read-only). Any write to 0x7F clears all collisions.
//  Reads of unmapped addresses return 0.
//  Bus timing: a write lands on the clk edge where enable && write_enable.
//   A read registers data_out on the edge where enable && !write_enable, so read latency is 1 cycle.
//  Line active: (vpos - posy) mod 2^POS_WIDTH < height. height 0 means never drawn.
//  Per-object FSM (sub-module), states:
//   IDLE: trigger = pixel_en && en && line active && hpos == posx.
//    On trigger, latch gfx, refl and stretch into shadows, clear the bit and repeat counters, go to DRAW.
//   DRAW: obj_value = shadow bit (refl=0: bit GFX_WIDTH-1 first; refl=1: bit 0 first).
//    Each bit is held for 2^stretch pixel_en cycles.
//    After GFX_WIDTH*2^stretch pixels, return to IDLE with obj_value 0.
//  Latency: obj_value is registered. It shows the first bit in the cycle after the trigger edge
//   and changes only on pixel_en edges.
//  Writes to any register during DRAW take effect at the next trigger. The shadows prevent tearing.
//  A trigger condition seen during DRAW is ignored. There is no retrigger, and a draw in progress
//   continues across the end of a line.
//  Clearing en during DRAW forces IDLE and obj_value 0 on the next edge.
//  posx past the line end never matches, so the object is not drawn. There is no wrap to the next line.
//  Collisions, one bit per pair i<j:
//   index k(i,j) = i*NUM_OBJECTS - i*(i+1)/2 + (j-i-1)
//   On a pixel_en edge, bit k is set when obj_value[i] && obj_value[j] is registered.
//   Bits are sticky until cleared.
//   A clear and a new collision on the same edge: the new collision bit survives, all others clear.
//   Bits at index >= NUM_OBJECTS*(NUM_OBJECTS-1)/2 read 0.
// STRUCTURE
//  sprite_bank_defs.vh: register offsets, OBJ_STRIDE=8, COLL_BASE=7'h78, COLL_CLEAR=7'h7F,
//   ctrl field positions, FSM state encodings IDLE/DRAW.
//  Sub-module sprite_object: one channel's registers, shadows, FSM and value output.
//   It is generated NUM_OBJECTS times.
//  The top level holds address decode, the read mux, the collision pair logic and the collision register.
// TESTING
//  1. Obj0 posx=100 posy=50 height=4 gfx=8'hA5 stretch=0 en, raster sweep
//     -> lines 50..53 output 1,0,1,0,0,1,0,1 on pixels 101..108; other lines 0.
//  2. Same with refl=1 and stretch=2 -> each bit held 4 pixels, order 1,0,1,0,0,1,0,1 (0xA5 is a palindrome).
//     Repeat with gfx=8'h80 -> 4-pixel pulse at the end with refl=1, at the start with refl=0.
//  3. Write gfx=8'h00 mid-DRAW -> current line unchanged; next line's draw shows all 0.
//  4. Obj0 and obj2 overlap at one pixel -> collision bit k(0,2)=1 read at 0x78; other bits 0.
//     Write 0x7F -> reads 0.
//  5. Clear on the same edge as a new obj1/obj3 overlap -> bit k(1,3) stays 1, others 0.
//  6. Assert reset mid-DRAW with collisions set -> obj_value, data_out and collisions are 0 asynchronously.
//     After release, no drawing until registers are reprogrammed.
//  Sweep NUM_OBJECTS=2 and 8, and POS_WIDTH=10 with posy=1020 and height=8
//   -> vertical wrap draws lines 1020..1023 and 0..3.

Source files
------------

// File: rtl/sprite_bank_pkg.sv
// Shared definitions for the sprite bank: register map offsets, control-byte
// field positions, the per-object FSM state type and the collision pair index.
// No ports; imported by sprite_object and sprite_bank.
package sprite_bank_pkg;

    // Register map: object i occupies OBJ_STRIDE bytes starting at OBJ_STRIDE*i.
    localparam int         OBJ_STRIDE  = 8;
    localparam logic [6:0] COLL_BASE   = 7'h78;  // collision bytes 0x78..0x7B
    localparam logic [6:0] COLL_CLEAR  = 7'h7F;  // any write clears collisions

    localparam logic [2:0] OFS_POSX_LO = 3'd0;
    localparam logic [2:0] OFS_POSX_HI = 3'd1;
    localparam logic [2:0] OFS_POSY_LO = 3'd2;
    localparam logic [2:0] OFS_POSY_HI = 3'd3;
    localparam logic [2:0] OFS_HEIGHT  = 3'd4;
    localparam logic [2:0] OFS_GFX     = 3'd5;
    localparam logic [2:0] OFS_CTRL    = 3'd6;

    // ctrl byte layout: {en[7], refl[3], stretch[1:0]}
    localparam int CTRL_EN      = 7;
    localparam int CTRL_REFL    = 3;
    localparam int CTRL_STR_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } obj_state_t;

    // Bit index of the collision flag for object pair (i, j), i < j.
    function automatic int pair_index(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/sprite_object.sv
// One sprite channel: its programmable registers, the draw shadows, the
// IDLE/DRAW FSM and the registered per-pixel value.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   pixel_en, hpos, vpos raster strobe and position
//   wr_en, offset, wr_data  decoded register write for this channel
//   rd_data             combinational readback of register at 'offset'
//   value               registered pixel value of this object
//   state               FSM state (debug visibility)
module sprite_object
    import sprite_bank_pkg::*;
#(
    parameter int GFX_WIDTH = 8,
    parameter int POS_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pixel_en,
    input  logic [POS_WIDTH-1:0] hpos,
    input  logic [POS_WIDTH-1:0] vpos,
    input  logic                 wr_en,
    input  logic [2:0]           offset,
    input  logic [7:0]           wr_data,
    output logic [7:0]           rd_data,
    output logic                 value,
    output obj_state_t           state
);

    localparam int BIT_W = (GFX_WIDTH > 1) ? $clog2(GFX_WIDTH) : 1;

    // Programmable registers
    logic [POS_WIDTH-1:0] posx, posy;
    logic [7:0]           height;
    logic [GFX_WIDTH-1:0] gfx;
    logic                 en, refl;
    logic [1:0]           stretch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            posx    <= '0;
            posy    <= '0;
            height  <= '0;
            gfx     <= '0;
            en      <= 1'b0;
            refl    <= 1'b0;
            stretch <= '0;
        end else if (wr_en) begin
            case (offset)
                OFS_POSX_LO: posx[7:0]           <= wr_data;
                OFS_POSX_HI: posx[POS_WIDTH-1:8] <= wr_data[POS_WIDTH-9:0];
                OFS_POSY_LO: posy[7:0]           <= wr_data;
                OFS_POSY_HI: posy[POS_WIDTH-1:8] <= wr_data[POS_WIDTH-9:0];
                OFS_HEIGHT:  height              <= wr_data;
                OFS_GFX:     gfx                 <= wr_data[GFX_WIDTH-1:0];
                OFS_CTRL: begin
                    en      <= wr_data[CTRL_EN];
                    refl    <= wr_data[CTRL_REFL];
                    stretch <= wr_data[CTRL_STR_LSB +: 2];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            OFS_POSX_LO: rd_data = posx[7:0];
            OFS_POSX_HI: rd_data = 8'(posx[POS_WIDTH-1:8]);
            OFS_POSY_LO: rd_data = posy[7:0];
            OFS_POSY_HI: rd_data = 8'(posy[POS_WIDTH-1:8]);
            OFS_HEIGHT:  rd_data = height;
            OFS_GFX:     rd_data = 8'(gfx);
            OFS_CTRL: begin
                rd_data[CTRL_EN]            = en;
                rd_data[CTRL_REFL]          = refl;
                rd_data[CTRL_STR_LSB +: 2]  = stretch;
            end
            default: rd_data = '0;
        endcase
    end

    // Draw shadows and counters
    obj_state_t           state_n;
    logic [GFX_WIDTH-1:0] sh_gfx, sh_gfx_n;
    logic                 sh_refl, sh_refl_n;
    logic [1:0]           sh_stretch, sh_stretch_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [2:0]           rep_cnt, rep_cnt_n;
    logic                 value_n;

    logic [POS_WIDTH-1:0] line_dy;
    logic                 line_active, trigger, rep_last;
    logic [BIT_W-1:0]     next_bit, next_sel;

    always_comb begin
        state_n      = state;
        sh_gfx_n     = sh_gfx;
        sh_refl_n    = sh_refl;
        sh_stretch_n = sh_stretch;
        bit_cnt_n    = bit_cnt;
        rep_cnt_n    = rep_cnt;
        value_n      = value;

        // Modular distance handles sprites that wrap past the last line.
        line_dy     = vpos - posy;
        line_active = (line_dy < POS_WIDTH'(height));
        trigger     = pixel_en && en && line_active && (hpos == posx);

        // 3-bit modular arithmetic: stretch=3 gives 8-1 = 7 via wrap.
        rep_last = (rep_cnt == ((3'd1 << sh_stretch) - 3'd1));
        next_bit = bit_cnt + BIT_W'(1);
        next_sel = sh_refl ? next_bit : (BIT_W'(GFX_WIDTH - 1) - next_bit);

        case (state)
            IDLE: begin
                value_n = 1'b0;
                if (trigger) begin
                    state_n      = DRAW;
                    sh_gfx_n     = gfx;
                    sh_refl_n    = refl;
                    sh_stretch_n = stretch;
                    bit_cnt_n    = '0;
                    rep_cnt_n    = '0;
                    value_n      = refl ? gfx[0] : gfx[GFX_WIDTH-1];
                end
            end
            DRAW: begin
                if (!en) begin
                    state_n = IDLE;
                    value_n = 1'b0;
                end else if (pixel_en) begin
                    if (rep_last) begin
                        rep_cnt_n = '0;
                        if (bit_cnt == BIT_W'(GFX_WIDTH - 1)) begin
                            state_n = IDLE;
                            value_n = 1'b0;
                        end else begin
                            bit_cnt_n = next_bit;
                            value_n   = sh_gfx[next_sel];
                        end
                    end else begin
                        rep_cnt_n = rep_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                value_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sh_gfx     <= '0;
            sh_refl    <= 1'b0;
            sh_stretch <= '0;
            bit_cnt    <= '0;
            rep_cnt    <= '0;
            value      <= 1'b0;
        end else begin
            state      <= state_n;
            sh_gfx     <= sh_gfx_n;
            sh_refl    <= sh_refl_n;
            sh_stretch <= sh_stretch_n;
            bit_cnt    <= bit_cnt_n;
            rep_cnt    <= rep_cnt_n;
            value      <= value_n;
        end
    end

endmodule

// File: rtl/sprite_bank.sv
// Bank of NUM_OBJECTS sprite channels behind one byte-wide register bus.
// Holds address decode, the registered read mux and the sticky pairwise
// collision register.
// Bus handshake: a transfer happens on any rising clk edge with enable high;
// write_enable selects write (lands that edge) or read (data_out registered
// that edge, visible the following cycle). There is no back-pressure.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   pixel_en, hpos, vpos         raster strobe and position
//   enable, write_enable         bus select / write qualifier
//   address, data_in, data_out   7-bit address, write data, registered read data
//   obj_value                    per-object pixel value
//   obj_state                    per-object FSM state, 1 = DRAW (debug)
module sprite_bank
    import sprite_bank_pkg::*;
#(
    parameter int NUM_OBJECTS = 5,
    parameter int GFX_WIDTH   = 8,
    parameter int POS_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixel_en,
    input  logic [POS_WIDTH-1:0]   hpos,
    input  logic [POS_WIDTH-1:0]   vpos,
    input  logic                   enable,
    input  logic                   write_enable,
    input  logic [6:0]             address,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic [NUM_OBJECTS-1:0] obj_value,
    output logic [NUM_OBJECTS-1:0] obj_state
);

    logic wr_strobe, rd_strobe;
    assign wr_strobe = enable && write_enable;
    assign rd_strobe = enable && !write_enable;

    logic [NUM_OBJECTS-1:0] obj_sel;
    logic [7:0]             obj_rd [NUM_OBJECTS];

    for (genvar i = 0; i < NUM_OBJECTS; i++) begin : g_obj
        obj_state_t st;

        assign obj_sel[i] = (address >= 7'(OBJ_STRIDE * i)) &&
                            (address <  7'(OBJ_STRIDE * (i + 1)));

        sprite_object #(
            .GFX_WIDTH (GFX_WIDTH),
            .POS_WIDTH (POS_WIDTH)
        ) u_obj (
            .clk      (clk),
            .reset    (reset),
            .pixel_en (pixel_en),
            .hpos     (hpos),
            .vpos     (vpos),
            .wr_en    (wr_strobe && obj_sel[i]),
            .offset   (address[2:0]),
            .wr_data  (data_in),
            .rd_data  (obj_rd[i]),
            .value    (obj_value[i]),
            .state    (st)
        );

        assign obj_state[i] = (st == DRAW);
    end

    // Collisions are judged on the pixel currently shown, i.e. the
    // registered obj_value at a pixel_en edge.
    logic [31:0] coll, hits;
    logic        coll_clear;

    always_comb begin
        hits = '0;
        if (pixel_en) begin
            for (int i = 0; i < NUM_OBJECTS; i++) begin
                for (int j = i + 1; j < NUM_OBJECTS; j++) begin
                    hits[5'(pair_index(i, j, NUM_OBJECTS))] = obj_value[i] & obj_value[j];
                end
            end
        end
    end

    assign coll_clear = wr_strobe && (address == COLL_CLEAR);

    logic [7:0] rd_val;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_OBJECTS; i++) begin
            if (obj_sel[i]) rd_val = obj_rd[i];
        end
        if (address[6:2] == COLL_BASE[6:2]) rd_val = coll[{address[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coll     <= '0;
            data_out <= '0;
        end else begin
            // A clear keeps only the collisions detected on the same edge.
            coll <= coll_clear ? hits : (coll | hits);
            if (rd_strobe) data_out <= rd_val;
        end
    end

endmodule

// File: tb/tb_sprite_bank.sv
// Directed bench for sprite_bank: raster sweeps with hand-computed pixel
// patterns, collision set/clear, wrap, reset mid-draw.
module tb_sprite_bank;

    localparam int N_OBJ = 5;
    localparam int H0    = 96;
    localparam int NO_WR = -1;

    logic             clk, reset, pixel_en, enable, write_enable;
    logic [9:0]       hpos, vpos;
    logic [6:0]       address;
    logic [7:0]       data_in, data_out;
    logic [N_OBJ-1:0] obj_value, obj_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] line_bits [N_OBJ];
    int wrap_lines [6] = '{1019, 1020, 1023, 0, 3, 4};

    sprite_bank #(.NUM_OBJECTS(N_OBJ), .GFX_WIDTH(8), .POS_WIDTH(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_en     (pixel_en),
        .hpos         (hpos),
        .vpos         (vpos),
        .enable       (enable),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .obj_value    (obj_value),
        .obj_state    (obj_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
        enable = 1'b1; write_enable = 1'b1; address = a; data_in = d;
        tick();
        enable = 1'b0; write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [7:0] d);
        enable = 1'b1; write_enable = 1'b0; address = a;
        tick();
        enable = 1'b0;
        d = data_out;
    endtask

    task automatic read_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        bus_read(a, rd);
        check(tag, rd, exp);
    endtask

    task automatic prog_obj(input int i, input logic [9:0] px, input logic [9:0] py,
                            input logic [7:0] h, input logic [7:0] g, input logic [7:0] c);
        logic [6:0] b;
        b = 7'(8 * i);
        bus_write(b + 7'd0, px[7:0]);
        bus_write(b + 7'd1, {6'b0, px[9:8]});
        bus_write(b + 7'd2, py[7:0]);
        bus_write(b + 7'd3, {6'b0, py[9:8]});
        bus_write(b + 7'd4, h);
        bus_write(b + 7'd5, g);
        bus_write(b + 7'd6, c);
    endtask

    // Sweep pixels H0..H0+63 of line v; line_bits[o][p] is obj o's value
    // shown while pixel H0+p is presented. Optional bus write at pixel wr_h.
    task automatic sweep_line(input int v, input int wr_h, input logic [6:0] wa, input logic [7:0] wd);
        for (int p = 0; p < 64; p++) begin
            vpos = 10'(v); hpos = 10'(H0 + p); pixel_en = 1'b1;
            if (H0 + p == wr_h) begin
                enable = 1'b1; write_enable = 1'b1; address = wa; data_in = wd;
            end
            for (int o = 0; o < N_OBJ; o++) line_bits[o][p] = obj_value[o];
            tick();
            enable = 1'b0; write_enable = 1'b0;
        end
        pixel_en = 1'b0; hpos = '0;
        tick();
    endtask

    initial begin
        reset = 1'b0; pixel_en = 1'b0; enable = 1'b0; write_enable = 1'b0;
        hpos = '0; vpos = '0; address = '0; data_in = '0;
        tick(); tick();
        check("rst_data_out", data_out, 8'h00);
        check("rst_obj_value", obj_value, 5'h00);
        check("rst_obj_state", obj_state, 5'h00);
        reset = 1'b1;
        tick();

        // Test 1: basic draw, lines 50..53
        prog_obj(0, 100, 50, 4, 8'hA5, 8'h80);
        read_check("t1_rd_gfx", 7'h05, 8'hA5);
        read_check("t1_rd_ctrl", 7'h06, 8'h80);
        for (int l = 48; l < 56; l++)
            exp_q.push_back((l >= 50 && l <= 53) ? 64'h14A0 : 64'h0);
        for (int l = 48; l < 56; l++) begin
            sweep_line(l, NO_WR, '0, '0);
            check($sformatf("t1_line%0d", l), line_bits[0], exp_q.pop_front());
        end

        // Test 2: reflection and stretch
        bus_write(7'h06, 8'h8A);
        sweep_line(50, NO_WR, '0, '0);
        check("t2_refl_str2_a5", line_bits[0], 64'h0000_001E_1E01_E1E0);
        bus_write(7'h05, 8'h80);
        sweep_line(51, NO_WR, '0, '0);
        check("t2_refl_80", line_bits[0], 64'h0000_001E_0000_0000);
        bus_write(7'h06, 8'h82);
        sweep_line(52, NO_WR, '0, '0);
        check("t2_norefl_80", line_bits[0], 64'h0000_0000_0000_01E0);

        // Test 3: gfx write mid-draw uses shadows
        bus_write(7'h05, 8'hA5);
        bus_write(7'h06, 8'h80);
        sweep_line(50, 104, 7'h05, 8'h00);
        check("t3_line_unchanged", line_bits[0], 64'h14A0);
        sweep_line(51, NO_WR, '0, '0);
        check("t3_next_line_zero", line_bits[0], 64'h0);

        // Clearing en mid-draw stops after the next edge
        bus_write(7'h05, 8'hFF);
        bus_write(7'h06, 8'h80);
        sweep_line(52, 103, 7'h06, 8'h00);
        check("en_clear_mid", line_bits[0], 64'h1E0);
        sweep_line(53, NO_WR, '0, '0);
        check("en_clear_next", line_bits[0], 64'h0);

        // Test 4: obj0/obj2 collide at pixel 108
        prog_obj(0, 100, 50, 1, 8'h01, 8'h80);
        prog_obj(2, 107, 50, 1, 8'h80, 8'h80);
        bus_write(7'h7F, 8'h00);
        sweep_line(50, NO_WR, '0, '0);
        check("t4_obj0_px", line_bits[0], 64'h1000);
        check("t4_obj2_px", line_bits[2], 64'h1000);
        read_check("t4_coll0", 7'h78, 8'h02);
        read_check("t4_coll1", 7'h79, 8'h00);
        bus_write(7'h7F, 8'h00);
        read_check("t4_coll_cleared", 7'h78, 8'h00);

        // Test 5: clear on same edge as new obj1/obj3 collision
        prog_obj(1, 110, 52, 1, 8'h80, 8'h80);
        prog_obj(3, 110, 52, 1, 8'h80, 8'h80);
        sweep_line(50, NO_WR, '0, '0);
        read_check("t5_coll_before", 7'h78, 8'h02);
        sweep_line(52, 111, 7'h7F, 8'h00);
        check("t5_obj1_px", line_bits[1], 64'h8000);
        read_check("t5_coll_after", 7'h78, 8'h20);

        // Last pair (3,4) lands in byte 1; unmapped reads
        bus_write(7'h1A, 8'd54);
        prog_obj(4, 110, 54, 1, 8'h80, 8'h80);
        bus_write(7'h7F, 8'h00);
        sweep_line(54, NO_WR, '0, '0);
        read_check("pair34_byte1", 7'h79, 8'h02);
        read_check("pair34_byte0", 7'h78, 8'h00);
        read_check("rd_obj4_posx", 7'h20, 8'h6E);
        read_check("rd_unmapped_07", 7'h07, 8'h00);
        read_check("rd_unmapped_40", 7'h40, 8'h00);
        read_check("rd_unmapped_7c", 7'h7C, 8'h00);

        // Vertical wrap: posy=1020, height 8
        prog_obj(0, 100, 1020, 8, 8'hA5, 8'h80);
        read_check("wrap_rd_posy_hi", 7'h03, 8'h03);
        for (int k = 0; k < 6; k++) begin
            sweep_line(wrap_lines[k], NO_WR, '0, '0);
            check($sformatf("wrap_line%0d", wrap_lines[k]), line_bits[0],
                  (k == 0 || k == 5) ? 64'h0 : 64'h14A0);
        end

        // Test 6: reset mid-draw with a collision set
        prog_obj(0, 100, 50, 4, 8'hFF, 8'h83);
        bus_write(7'h7F, 8'h00);
        read_check("t6_rd_ctrl", 7'h06, 8'h83);
        for (int h = 96; h <= 110; h++) begin
            vpos = 10'd50; hpos = 10'(h); pixel_en = 1'b1;
            tick();
        end
        pixel_en = 1'b0;
        check("t6_drawing", obj_value[0], 1'b1);
        check("t6_data_out_pre", data_out, 8'h83);
        #2 reset = 1'b0;
        #1;
        check("t6_async_obj_value", obj_value, 5'h00);
        check("t6_async_data_out", data_out, 8'h00);
        check("t6_async_state", obj_state, 5'h00);
        tick(); tick();
        reset = 1'b1;
        tick();
        read_check("t6_coll_after", 7'h78, 8'h00);
        read_check("t6_ctrl_after", 7'h06, 8'h00);
        sweep_line(50, NO_WR, '0, '0);
        check("t6_no_draw_obj0", line_bits[0], 64'h0);
        check("t6_no_draw_obj2", line_bits[2], 64'h0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
